// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine.
// A CPU write to the DMA register latches a source page. The block then copies
// BYTE_COUNT bytes from {page,8'h00} into OAM using a read/write cycle pair
// per byte. Echo-RAM pages E0..FF are remapped down by 8'h20.
module oam_dma #(
  parameter int unsigned BYTE_COUNT  = 160,
  parameter logic [3:0]  DMA_REG_SEL = 4'd6
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iMcuWe,
  input  logic [3:0]  iMcuRegSelect,
  input  logic [7:0]  iMcuWriteData,
  output logic [7:0]  oDMA,
  output logic        oDmaActive,
  output logic [15:0] oMcuAddr,
  output logic        oMcuReadRequest,
  input  logic [7:0]  iMcuReadData,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(BYTE_COUNT - 1);

  state_t     state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [7:0] src_q,   src_d;
  logic [7:0] dma_q,   dma_d;

  logic       trigger;
  logic [7:0] src_remapped;

  assign trigger      = iMcuWe && (iMcuRegSelect == DMA_REG_SEL);
  assign src_remapped = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
  assign oDMA         = dma_q;

  // State register: async active-low reset.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      src_q   <= '0;
      dma_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      src_q   <= src_d;
      dma_q   <= dma_d;
    end
  end

  // Next-state logic; a trigger overrides any state, including a WRITE cycle
  // whose strobe still fires because outputs are decoded from state_q.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    src_d   = src_q;
    dma_d   = dma_q;
    if (trigger) begin
      dma_d   = iMcuWriteData;
      src_d   = iMcuWriteData;
      index_d = '0;
      state_d = S_START;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_START: state_d = S_READ;
        S_READ:  state_d = S_WRITE;
        S_WRITE: begin
          if (index_q == LAST_INDEX) begin
            state_d = S_IDLE;
          end else begin
            index_d = index_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    oDmaActive      = 1'b0;
    oMcuAddr        = '0;
    oMcuReadRequest = 1'b0;
    oOamWe          = 1'b0;
    oOamAddr        = '0;
    oOamData        = '0;
    case (state_q)
      S_IDLE: begin
        oDmaActive = 1'b0;
      end
      S_START: begin
        oDmaActive = 1'b1;
      end
      S_READ: begin
        oDmaActive      = 1'b1;
        oMcuAddr        = {src_remapped, index_q};
        oMcuReadRequest = 1'b1;
      end
      S_WRITE: begin
        oDmaActive = 1'b1;
        oOamWe     = 1'b1;
        oOamAddr   = index_q;
        oOamData   = iMcuReadData;
      end
      default: oDmaActive = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized and directed bench for oam_dma with a timing-based
// reference model (cycle offset from the trigger edge determines outputs).
module tb_oam_dma;

  localparam int NB = 160;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  sel;
  logic [7:0]  wdata;
  logic [7:0]  dma_o;
  logic        active;
  logic [15:0] maddr;
  logic        mreq;
  logic [7:0]  rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;

  oam_dma #(.BYTE_COUNT(NB), .DMA_REG_SEL(4'd6)) dut (
    .iClock(clk),
    .iReset(rst_n),
    .iMcuWe(we),
    .iMcuRegSelect(sel),
    .iMcuWriteData(wdata),
    .oDMA(dma_o),
    .oDmaActive(active),
    .oMcuAddr(maddr),
    .oMcuReadRequest(mreq),
    .iMcuReadData(rdata),
    .oOamWe(oam_we),
    .oOamAddr(oam_addr),
    .oOamData(oam_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];

  int cyc = 0;
  int wr_cnt = 0;
  int act_cnt = 0;
  int first_wr_cyc = -1;

  always @(posedge clk) cyc++;

  // MMU read path: data returned exactly one cycle after the request.
  always @(posedge clk) begin
    if (mreq) rdata <= mem[maddr];
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic logic [7:0] remap(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  // Reference model: phase = cycles since the trigger edge (1 = dead cycle),
  // -1 when idle. Even phases >=2 read, odd phases >=3 write.
  int         phase = -1;
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_dma = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = -1;
      m_dma = 8'h00;
    end else if (we && sel == 4'd6) begin
      phase  = 1;
      m_page = wdata;
      m_dma  = wdata;
    end else if (phase >= 1) begin
      phase++;
      if (phase > 2 * NB + 1) phase = -1;
    end
  end

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    logic       e_act, e_rd, e_wr;
    int         idx;
    e_act = (phase >= 1);
    e_rd  = (phase >= 2) && (phase % 2 == 0);
    e_wr  = (phase >= 3) && (phase % 2 == 1);
    chk("active", active, e_act);
    chk("read_req", mreq, e_rd);
    chk("oam_we", oam_we, e_wr);
    chk("dma_reg", dma_o, m_dma);
    if (!rst_n) begin
      chk("rst_addr", maddr, 0);
      chk("rst_oam_addr", oam_addr, 0);
      chk("rst_oam_data", oam_data, 0);
    end
    if (e_rd) begin
      idx = (phase - 2) / 2;
      chk("src_addr", maddr, {remap(m_page), 8'(idx)});
    end
    if (e_wr) begin
      idx = (phase - 3) / 2;
      chk("oam_addr", oam_addr, idx);
      chk("oam_data", oam_data, mem[{remap(m_page), 8'(idx)}]);
    end
    if (oam_we) begin
      if (wr_cnt == 0) first_wr_cyc = cyc;
      wr_cnt++;
      oam[oam_addr] = oam_data;
    end
    if (active) act_cnt++;
  end

  // Register write: inputs change 1 time unit after an edge; the write is
  // sampled on the following edge. Returns just after that sampling edge.
  task automatic reg_write(input logic [3:0] s, input logic [7:0] d);
    @(posedge clk);
    #1;
    we    = 1'b1;
    sel   = s;
    wdata = d;
    @(posedge clk);
    #1;
    we    = 1'b0;
    sel   = 4'd0;
    wdata = $urandom_range(0, 255);
  endtask

  task automatic clear_counts();
    wr_cnt       = 0;
    act_cnt      = 0;
    first_wr_cyc = -1;
  endtask

  initial begin
    int trig_cyc;
    int r;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    for (int i = 0; i < NB; i++) begin
      mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
      mem[16'hC300 + i] = ~8'(i);
      mem[16'hD000 + i] = 8'(i) + 8'h33;
    end
    we    = 1'b0;
    sel   = 4'd0;
    wdata = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    clear_counts();
    repeat (10) @(posedge clk);
    #1;
    chk("idle_writes", wr_cnt, 0);
    chk("idle_active", act_cnt, 0);
    chk("idle_dma", dma_o, 8'h00);

    // Full transfer from C1.
    clear_counts();
    reg_write(4'd6, 8'hC1);
    trig_cyc = cyc;
    repeat (330) @(posedge clk);
    #1;
    chk("c1_writes", wr_cnt, 160);
    chk("c1_active_span", act_cnt, 321);
    chk("c1_first_write_latency", first_wr_cyc - trig_cyc, 2);
    chk("c1_oam0", oam[0], 8'h5A);
    chk("c1_oam5", oam[5], 8'h5F);
    chk("c1_oam159", oam[159], 8'hC5);
    chk("c1_dma", dma_o, 8'hC1);

    // Echo-RAM page E3 reads from C3.
    clear_counts();
    reg_write(4'd6, 8'hE3);
    repeat (330) @(posedge clk);
    #1;
    chk("e3_writes", wr_cnt, 160);
    chk("e3_oam7", oam[7], 8'hF8);
    chk("e3_dma", dma_o, 8'hE3);

    // Other select ignored.
    clear_counts();
    reg_write(4'd5, 8'hC1);
    repeat (20) @(posedge clk);
    #1;
    chk("sel5_writes", wr_cnt, 0);
    chk("sel5_active", act_cnt, 0);
    chk("sel5_dma", dma_o, 8'hE3);

    // Retrigger with D0 at the edge closing cycle T+51 (WRITE of index 24).
    clear_counts();
    reg_write(4'd6, 8'hC1);
    repeat (49) @(posedge clk);
    reg_write(4'd6, 8'hD0);
    repeat (340) @(posedge clk);
    #1;
    chk("retrig_writes", wr_cnt, 185);
    chk("retrig_active_span", act_cnt, 372);
    chk("retrig_oam0", oam[0], 8'h33);
    chk("retrig_oam159", oam[159], 8'hD2);
    chk("retrig_dma", dma_o, 8'hD0);

    // Async reset at T+100 of a transfer.
    reg_write(4'd6, 8'hC1);
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_active", active, 0);
    chk("arst_req", mreq, 0);
    chk("arst_we", oam_we, 0);
    chk("arst_dma", dma_o, 0);
    chk("arst_addr", maddr, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counts();
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_writes", wr_cnt, 0);
    clear_counts();
    reg_write(4'd6, 8'hE3);
    trig_cyc = cyc;
    repeat (330) @(posedge clk);
    #1;
    chk("restart_writes", wr_cnt, 160);
    chk("restart_active_span", act_cnt, 321);
    chk("restart_first_write_latency", first_wr_cyc - trig_cyc, 2);
    chk("restart_oam7", oam[7], 8'hF8);

    // Random traffic: random pages and selects, retriggers, resets.
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 14);
        if (r >= 6) r++;
        reg_write(4'(r), 8'($urandom_range(0, 255)));
      end else begin
        reg_write(4'd6, 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 300)) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        repeat ($urandom_range(0, 350)) @(posedge clk);
      end
    end
    repeat (340) @(posedge clk);
    #1;
    chk("final_idle", active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
